tcp_tx_arbiter: RTL and testbench
=================================

TCP_TX_ARBITER -- requirements
Module: tcp_tx_arbiter

Interface
REQ-001 SHALL have parameter USERW, default 1, width of the User sideband.
REQ-002 SHALL have port Clock  input  1  single clock; all state is clocked on its rising edge.
REQ-003 SHALL have port Reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports S0_Data/S1_Data  input  64  source payload beats.
REQ-005 SHALL have ports S0_Keep/S1_Keep  input  8  byte enables; S0_User/S1_User  input  USERW  sideband.
REQ-006 SHALL have ports S0_Last/S1_Last, S0_Valid/S1_Valid  input  1  end-of-packet and beat-valid.
REQ-007 SHALL have ports S0_Ready/S1_Ready  output  1  source beat accepted when Valid&&Ready.
REQ-008 SHALL have ports M_Data 64, M_Keep 8, M_User USERW, M_Last 1, M_Valid 1  output  merged stream.
REQ-009 SHALL have port M_Ready  input  1  downstream accepts when M_Valid&&M_Ready.
REQ-010 SHALL have port PortEnable  input  2  bit i permits new grants to source i.
REQ-011 SHALL have port Grant  output  2  one-hot current owner, 2'b00 when none.
REQ-012 SHALL have port Busy  output  1  high while in XFER or output buffer non-empty.
REQ-013 SHALL have ports PktCount0/PktCount1  output  16  packets forwarded per source.

Function
REQ-014 SHALL implement FSM states IDLE and XFER; arbitration only in IDLE.
REQ-015 In IDLE, candidates SHALL be sources with Valid=1 and PortEnable bit=1.
REQ-016 Arbitration SHALL be round-robin: source granted last has lowest priority; after reset source 0 has highest.
REQ-017 With >=1 candidate in IDLE, Grant SHALL be set to the winner and FSM SHALL enter XFER on the next edge (one-cycle arbitration bubble).
REQ-018 In XFER, Sx_Ready SHALL be 1 only for the granted source and only when the skid buffer is empty; non-granted Ready SHALL be 0.
REQ-019 Grant SHALL be held until the granted source's Last beat is accepted; no packet interleaving.
REQ-020 On acceptance of the Last beat, FSM SHALL return to IDLE, Grant SHALL clear and the RR pointer SHALL point past that source, all on the same edge.
REQ-021 PortEnable deasserting during XFER SHALL NOT abort the packet; it only blocks future grants.
REQ-022 Output SHALL be a 2-entry buffer (main + skid); Sx_Ready SHALL be registered with no combinational path from M_Ready.
REQ-023 Accepted beat SHALL appear on M_* the next cycle when the buffer is empty; full throughput of one beat/cycle within a packet while M_Ready=1.
REQ-024 M_Data/Keep/User/Last SHALL stay stable while M_Valid=1 and M_Ready=0; beat order SHALL be preserved.
REQ-025 Data/Keep/User/Last SHALL pass unmodified.
REQ-026 PktCountx SHALL increment by 1 when source x's Last beat is accepted, wrapping 16'hFFFF -> 16'h0000.
REQ-027 Single-beat packet (Valid&&Last on first beat) SHALL be handled as a complete packet.

Reset
REQ-028 Reset_n low SHALL asynchronously force FSM=IDLE, Grant=0, RR pointer=source 0, buffer empty, M_Valid=0, S0_Ready=S1_Ready=0, Busy=0, PktCount0=PktCount1=0.
REQ-029 Reset mid-packet SHALL discard the partial packet; after release, arbitration SHALL restart from IDLE.
REQ-030 Payload registers (M_Data, M_Keep, M_User, M_Last) need no reset value.

Verification
REQ-031 Both sources present 3-beat packets continuously, PortEnable=2'b11, M_Ready=1 -> order S0,S1,S0,S1; no interleaving; PktCount0/1 step 1,1,2,2.
REQ-032 S0 sends 4-beat packet, M_Ready held 0 for 5 cycles mid-packet -> M_* stable, no beat lost or duplicated, S0_Ready=0 while skid full.
REQ-033 S1 only, PortEnable=2'b01 -> Grant stays 2'b00, S1_Ready=0; set PortEnable=2'b10 -> S1 granted next cycle.
REQ-034 PortEnable[0] cleared during S0's 2nd of 5 beats -> all 5 beats forwarded, then S1 granted.
REQ-035 Preload PktCount0 to 16'hFFFF via 65535 single-beat packets -> next packet yields 16'h0000.
REQ-036 Assert Reset_n low mid-packet -> M_Valid=0 and Grant=0 immediately (before next edge), counters 0.

Source files
------------

// File: rtl/tcp_tx_arbiter.sv
// Two-source packet arbiter for the TCP transmit path: round-robin grant per packet,
// merged onto one stream through a main + skid output buffer so source Ready stays registered.
module tcp_tx_arbiter #(
  parameter int USERW = 1
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [63:0]      S0_Data,
  input  logic [7:0]       S0_Keep,
  input  logic [USERW-1:0] S0_User,
  input  logic             S0_Last,
  input  logic             S0_Valid,
  output logic             S0_Ready,
  input  logic [63:0]      S1_Data,
  input  logic [7:0]       S1_Keep,
  input  logic [USERW-1:0] S1_User,
  input  logic             S1_Last,
  input  logic             S1_Valid,
  output logic             S1_Ready,
  output logic [63:0]      M_Data,
  output logic [7:0]       M_Keep,
  output logic [USERW-1:0] M_User,
  output logic             M_Last,
  output logic             M_Valid,
  input  logic             M_Ready,
  input  logic [1:0]       PortEnable,
  output logic [1:0]       Grant,
  output logic             Busy,
  output logic [15:0]      PktCount0,
  output logic [15:0]      PktCount1,
  output logic             DebugState
);

  // Handshake: a beat moves on any rising Clock edge where Valid && Ready are both high.
  // Valid must not wait on Ready; Ready here is a pure register, never a function of M_Ready
  // within the same cycle.

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t      state, state_n;
  logic [1:0]  grant_q, grant_n;
  logic        rr_ptr, rr_n;
  logic        s0_ready_q, s1_ready_q;
  logic        s0_ready_n, s1_ready_n;
  logic [15:0] pkt_count0, pkt_count1;

  logic             main_valid, main_valid_n;
  logic             skid_valid, skid_valid_n;
  logic [63:0]      main_data, skid_data;
  logic [7:0]       main_keep, skid_keep;
  logic [USERW-1:0] main_user, skid_user;
  logic             main_last, skid_last;

  logic [1:0]       cand;
  logic             win_idx;
  logic             in_sel;
  logic             in_fire;
  logic             in_last_fire;
  logic [63:0]      in_data;
  logic [7:0]       in_keep;
  logic [USERW-1:0] in_user;
  logic             in_last;
  logic             pop;
  logic             ld_main_in, ld_main_skid, ld_skid;

  // Arbitration candidates and round-robin winner: rr_ptr names the favoured source.
  always_comb begin
    cand    = {S1_Valid & PortEnable[1], S0_Valid & PortEnable[0]};
    win_idx = cand[rr_ptr] ? rr_ptr : ~rr_ptr;
  end

  // Input side mux; only the granted source can ever see Ready high.
  always_comb begin
    in_sel       = grant_q[1];
    in_data      = in_sel ? S1_Data : S0_Data;
    in_keep      = in_sel ? S1_Keep : S0_Keep;
    in_user      = in_sel ? S1_User : S0_User;
    in_last      = in_sel ? S1_Last : S0_Last;
    in_fire      = (S0_Valid & s0_ready_q) | (S1_Valid & s1_ready_q);
    in_last_fire = in_fire & in_last;
    pop          = main_valid & M_Ready;
  end

  // Output buffer occupancy. A new beat lands in main when main is free this cycle,
  // otherwise it parks in skid and Ready drops on the following edge.
  always_comb begin
    main_valid_n = main_valid;
    skid_valid_n = skid_valid;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (pop) begin
      if (skid_valid) begin
        ld_main_skid = 1'b1;
        skid_valid_n = 1'b0;
      end else begin
        main_valid_n = 1'b0;
      end
    end
    if (in_fire) begin
      if (!main_valid || (pop && !skid_valid)) begin
        ld_main_in   = 1'b1;
        main_valid_n = 1'b1;
      end else begin
        ld_skid      = 1'b1;
        skid_valid_n = 1'b1;
      end
    end
  end

  // Next-state logic for arbitration, packet ownership and registered Ready.
  always_comb begin
    state_n = state;
    grant_n = grant_q;
    rr_n    = rr_ptr;
    case (state)
      IDLE: begin
        if (|cand) begin
          state_n = XFER;
          grant_n = win_idx ? 2'b10 : 2'b01;
        end
      end
      XFER: begin
        if (in_last_fire) begin
          state_n = IDLE;
          grant_n = 2'b00;
          rr_n    = grant_q[0];
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = 2'b00;
      end
    endcase
    s0_ready_n = (state_n == XFER) & grant_n[0] & ~skid_valid_n;
    s1_ready_n = (state_n == XFER) & grant_n[1] & ~skid_valid_n;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      grant_q    <= 2'b00;
      rr_ptr     <= 1'b0;
      s0_ready_q <= 1'b0;
      s1_ready_q <= 1'b0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      pkt_count0 <= 16'h0000;
      pkt_count1 <= 16'h0000;
    end else begin
      state      <= state_n;
      grant_q    <= grant_n;
      rr_ptr     <= rr_n;
      s0_ready_q <= s0_ready_n;
      s1_ready_q <= s1_ready_n;
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
      if (in_last_fire && grant_q[0]) pkt_count0 <= pkt_count0 + 16'h0001;
      if (in_last_fire && grant_q[1]) pkt_count1 <= pkt_count1 + 16'h0001;
    end
  end

  // Payload holds carry no reset; their contents only matter while the matching valid is set.
  always_ff @(posedge Clock) begin
    if (ld_main_in) begin
      main_data <= in_data;
      main_keep <= in_keep;
      main_user <= in_user;
      main_last <= in_last;
    end else if (ld_main_skid) begin
      main_data <= skid_data;
      main_keep <= skid_keep;
      main_user <= skid_user;
      main_last <= skid_last;
    end
    if (ld_skid) begin
      skid_data <= in_data;
      skid_keep <= in_keep;
      skid_user <= in_user;
      skid_last <= in_last;
    end
  end

  assign S0_Ready   = s0_ready_q;
  assign S1_Ready   = s1_ready_q;
  assign M_Data     = main_data;
  assign M_Keep     = main_keep;
  assign M_User     = main_user;
  assign M_Last     = main_last;
  assign M_Valid    = main_valid;
  assign Grant      = grant_q;
  assign Busy       = (state == XFER) | main_valid | skid_valid;
  assign PktCount0  = pkt_count0;
  assign PktCount1  = pkt_count1;
  assign DebugState = state;

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Directed bench for tcp_tx_arbiter: queued source packets, merged-stream scoreboard,
// immediate assertions at each comparison point.
module tb_tcp_tx_arbiter;

  localparam int W = 74; // {user, last, keep[7:0], data[63:0]}

  logic        Clock;
  logic        Reset_n;
  logic [63:0] S0_Data, S1_Data;
  logic [7:0]  S0_Keep, S1_Keep;
  logic [0:0]  S0_User, S1_User;
  logic        S0_Last, S1_Last, S0_Valid, S1_Valid;
  logic        S0_Ready, S1_Ready;
  logic [63:0] M_Data;
  logic [7:0]  M_Keep;
  logic [0:0]  M_User;
  logic        M_Last, M_Valid, M_Ready;
  logic [1:0]  PortEnable;
  logic [1:0]  Grant;
  logic        Busy;
  logic [15:0] PktCount0, PktCount1;
  logic        DebugState;

  tcp_tx_arbiter #(.USERW(1)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .S0_Data(S0_Data), .S0_Keep(S0_Keep), .S0_User(S0_User), .S0_Last(S0_Last),
    .S0_Valid(S0_Valid), .S0_Ready(S0_Ready),
    .S1_Data(S1_Data), .S1_Keep(S1_Keep), .S1_User(S1_User), .S1_Last(S1_Last),
    .S1_Valid(S1_Valid), .S1_Ready(S1_Ready),
    .M_Data(M_Data), .M_Keep(M_Keep), .M_User(M_User), .M_Last(M_Last),
    .M_Valid(M_Valid), .M_Ready(M_Ready),
    .PortEnable(PortEnable), .Grant(Grant), .Busy(Busy),
    .PktCount0(PktCount0), .PktCount1(PktCount1), .DebugState(DebugState)
  );

  // clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] s0_q[$], s1_q[$];
  logic [W-1:0] pend0_q[$], pend1_q[$];
  logic [1:0]   grant_log[$];
  logic [1:0]   g_prev = 2'b00;
  logic [W-1:0] b0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_beat(input int src, input int pkt, input int beat, input bit last);
    logic [63:0] d;
    logic [7:0]  s8, p8, b8;
    s8 = 8'hA0 + src[7:0];
    p8 = pkt[7:0];
    b8 = beat[7:0];
    d  = {s8, p8, b8, 8'h00, $urandom()};
    return {beat[0], last, (last ? 8'h0F : 8'hFF), d};
  endfunction

  // driver tasks
  task automatic drive_sources();
    if (s0_q.size() > 0) begin
      {S0_User, S0_Last, S0_Keep, S0_Data} = s0_q[0];
      S0_Valid = 1'b1;
    end else begin
      {S0_User, S0_Last, S0_Keep, S0_Data} = '0;
      S0_Valid = 1'b0;
    end
    if (s1_q.size() > 0) begin
      {S1_User, S1_Last, S1_Keep, S1_Data} = s1_q[0];
      S1_Valid = 1'b1;
    end else begin
      {S1_User, S1_Last, S1_Keep, S1_Data} = '0;
      S1_Valid = 1'b0;
    end
  endtask

  task automatic add_pkt(input int src, input int pkt, input int nbeats);
    logic [W-1:0] bt;
    for (int b = 0; b < nbeats; b++) begin
      bt = mk_beat(src, pkt, b, (b == nbeats - 1));
      if (src == 0) begin
        s0_q.push_back(bt);
        pend0_q.push_back(bt);
      end else begin
        s1_q.push_back(bt);
        pend1_q.push_back(bt);
      end
    end
    drive_sources();
  endtask

  task automatic expect_pkt(input int src);
    logic [W-1:0] bt;
    bt = '0;
    while (!bt[72]) begin
      if (src == 0) begin
        if (pend0_q.size() == 0) break;
        bt = pend0_q.pop_front();
      end else begin
        if (pend1_q.size() == 0) break;
        bt = pend1_q.pop_front();
      end
      exp_q.push_back(bt);
    end
  endtask

  // One clock: sample handshakes at negedge, advance source queues just after posedge.
  task automatic tick();
    bit f0, f1;
    @(negedge Clock);
    if (M_Valid && M_Ready) got_q.push_back({M_User, M_Last, M_Keep, M_Data});
    f0 = S0_Valid && S0_Ready;
    f1 = S1_Valid && S1_Ready;
    if (Grant != g_prev && Grant != 2'b00) grant_log.push_back(Grant);
    g_prev = Grant;
    @(posedge Clock);
    #1;
    if (f0 && s0_q.size() > 0) void'(s0_q.pop_front());
    if (f1 && s1_q.size() > 0) void'(s1_q.pop_front());
    drive_sources();
  endtask

  task automatic wait_drain(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (s0_q.size() == 0 && s1_q.size() == 0 && !Busy) begin
        done = 1'b1;
        break;
      end
    end
    chk({tag, "_drained"}, W'(done), W'(1));
  endtask

  task automatic wait_mvalid(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (M_Valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_mvalid_seen"}, W'(seen), W'(1));
  endtask

  // scoreboard
  task automatic compare_stream(input string tag);
    int n;
    chk({tag, "_beat_count"}, W'(got_q.size()), W'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    Reset_n    = 1'b0;
    M_Ready    = 1'b1;
    PortEnable = 2'b00;
    drive_sources();
    #12;
    // reset state
    chk("rst_mvalid", W'(M_Valid), W'(0));
    chk("rst_grant", W'(Grant), W'(0));
    chk("rst_s0_ready", W'(S0_Ready), W'(0));
    chk("rst_s1_ready", W'(S1_Ready), W'(0));
    chk("rst_busy", W'(Busy), W'(0));
    chk("rst_cnt0", W'(PktCount0), W'(0));
    chk("rst_cnt1", W'(PktCount1), W'(0));
    chk("rst_state", W'(DebugState), W'(0));
    tick();
    Reset_n = 1'b1;
    tick();

    // alternating 3-beat packets from both sources
    PortEnable = 2'b11;
    grant_log.delete();
    add_pkt(0, 0, 3); add_pkt(0, 1, 3);
    add_pkt(1, 0, 3); add_pkt(1, 1, 3);
    expect_pkt(0); expect_pkt(1); expect_pkt(0); expect_pkt(1);
    wait_drain("rr", 60);
    compare_stream("rr");
    chk("rr_grant_len", W'(grant_log.size()), W'(4));
    if (grant_log.size() == 4) begin
      chk("rr_grant0", W'(grant_log[0]), W'(2'b01));
      chk("rr_grant1", W'(grant_log[1]), W'(2'b10));
      chk("rr_grant2", W'(grant_log[2]), W'(2'b01));
      chk("rr_grant3", W'(grant_log[3]), W'(2'b10));
    end
    chk("rr_cnt0", W'(PktCount0), W'(2));
    chk("rr_cnt1", W'(PktCount1), W'(2));

    // back-pressure mid-packet: output must hold, skid fills, Ready drops
    add_pkt(0, 2, 4);
    b0 = s0_q[0];
    wait_mvalid("bp", 10);
    M_Ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_hold%0d", i), {M_User, M_Last, M_Keep, M_Data}, b0);
      chk($sformatf("bp_valid%0d", i), W'(M_Valid), W'(1));
    end
    chk("bp_s0_ready_skid_full", W'(S0_Ready), W'(0));
    chk("bp_busy", W'(Busy), W'(1));
    M_Ready = 1'b1;
    expect_pkt(0);
    wait_drain("bp", 30);
    compare_stream("bp");
    chk("bp_cnt0", W'(PktCount0), W'(3));

    // S1 blocked by PortEnable, then released
    PortEnable = 2'b01;
    add_pkt(1, 2, 2);
    tick(); tick(); tick();
    chk("en_grant_blocked", W'(Grant), W'(0));
    chk("en_s1_ready_blocked", W'(S1_Ready), W'(0));
    PortEnable = 2'b10;
    tick();
    chk("en_grant_s1", W'(Grant), W'(2'b10));
    chk("en_state_xfer", W'(DebugState), W'(1));
    expect_pkt(1);
    wait_drain("en", 20);
    compare_stream("en");

    // PortEnable[0] dropped during S0's 2nd beat must not cut the packet
    PortEnable = 2'b11;
    grant_log.delete();
    add_pkt(0, 3, 5);
    add_pkt(1, 3, 2);
    begin
      bit granted;
      granted = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (Grant == 2'b01) begin
          granted = 1'b1;
          break;
        end
      end
      chk("pe_s0_granted", W'(granted), W'(1));
    end
    tick();
    PortEnable = 2'b10;
    expect_pkt(0); expect_pkt(1);
    wait_drain("pe", 40);
    compare_stream("pe");
    chk("pe_grant_len", W'(grant_log.size()), W'(2));
    if (grant_log.size() == 2) chk("pe_grant_then_s1", W'(grant_log[1]), W'(2'b10));
    chk("pe_cnt0", W'(PktCount0), W'(4));
    chk("pe_cnt1", W'(PktCount1), W'(4));

    // asynchronous reset mid-packet
    PortEnable = 2'b11;
    add_pkt(1, 4, 4);
    wait_mvalid("ar", 10);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("ar_mvalid", W'(M_Valid), W'(0));
    chk("ar_grant", W'(Grant), W'(0));
    chk("ar_s1_ready", W'(S1_Ready), W'(0));
    chk("ar_cnt0", W'(PktCount0), W'(0));
    chk("ar_cnt1", W'(PktCount1), W'(0));
    chk("ar_busy", W'(Busy), W'(0));
    s0_q.delete(); s1_q.delete(); pend0_q.delete(); pend1_q.delete();
    got_q.delete(); exp_q.delete();
    drive_sources();
    tick();
    Reset_n = 1'b1;
    tick();

    // restart from IDLE with a single-beat packet
    add_pkt(1, 5, 1);
    expect_pkt(1);
    wait_drain("sb", 20);
    compare_stream("sb");
    chk("sb_cnt1", W'(PktCount1), W'(1));
    chk("sb_cnt0", W'(PktCount0), W'(0));

    // 65535 real packets would need ~131k cycles, so the counter is loaded by backdoor
    #2;
    force dut.pkt_count0 = 16'hFFFF;
    #1;
    release dut.pkt_count0;
    tick();
    chk("wrap_preload", W'(PktCount0), W'(16'hFFFF));
    add_pkt(0, 6, 1);
    expect_pkt(0);
    wait_drain("wrap", 20);
    compare_stream("wrap");
    chk("wrap_cnt0", W'(PktCount0), W'(16'h0000));
    chk("wrap_cnt1", W'(PktCount1), W'(1));

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
